sr_dbg_port_arbiter: RTL and testbench



---
 rtl/sr_dbg_pkg.sv | 12 +
 rtl/sr_dbg_port_arbiter_if.sv | 31 +++
 rtl/sr_rr_pick.sv | 25 ++
 rtl/sr_dbg_port_arbiter.sv | 68 ++++++
 tb/tb_sr_dbg_port_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sr_dbg_pkg.sv
// Shared definitions for the debug register-port arbiter.
//   REG_AW  : width of a CPU register address (x0..x31)
//   state_e : arbiter FSM state encoding
package sr_dbg_pkg;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/sr_dbg_port_arbiter_if.sv
// Bundle between the debug consumers, the arbiter and the CPU debug port.
//   req/req_addr : per-requester level request and register address
//   ack/rdata    : one-hot completion pulse and captured register value
//   busy         : transaction in progress
//   grant_idx    : requester currently or last served
//   regAddr      : address to the CPU debug port
//   regData      : combinational data from the CPU debug port
// slave is the arbiter's view; master is the view of everything around it.
interface sr_dbg_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]                     req;
  logic [sr_dbg_pkg::REG_AW*N_REQ-1:0]  req_addr;
  logic [N_REQ-1:0]                     ack;
  logic [31:0]                          rdata;
  logic                                 busy;
  logic [IDX_W-1:0]                     grant_idx;
  logic [sr_dbg_pkg::REG_AW-1:0]        regAddr;
  logic [31:0]                          regData;

  modport slave (
    input  req, req_addr, regData,
    output ack, rdata, busy, grant_idx, regAddr
  );

  modport master (
    output req, req_addr, regData,
    input  ack, rdata, busy, grant_idx, regAddr
  );
endinterface

// File: rtl/sr_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority position
//   any : at least one request set
//   idx : first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1
// ptr must be < N.
module sr_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N])
        idx = IW'((int'(ptr) + off) % N);
    end
  end
endmodule

// File: rtl/sr_dbg_port_arbiter.sv
// Round-robin arbiter sharing the CPU's single debug register-read port.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave view of sr_dbg_port_arbiter_if (requesters + CPU port)
// Each read takes IDLE -> READ -> ACK: the address is latched on the grant
// edge, driven to the CPU for one whole cycle, the data captured at the end
// of that cycle and returned with a one-cycle ack.
module sr_dbg_port_arbiter
  import sr_dbg_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_dbg_port_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic             pickAny;
  logic [IDX_W-1:0] pickIdx;

  sr_rr_pick #(.N(N_REQ), .IW(IDX_W)) uPick (
    .req (bus.req),
    .ptr (ptr),
    .any (pickAny),
    .idx (pickIdx)
  );

  // regAddr doubles as the latched address: it is nonzero only in READ,
  // so later changes on req_addr cannot reach the CPU port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.ack       <= '0;
      bus.rdata     <= '0;
      bus.regAddr   <= '0;
      bus.busy      <= 1'b0;
      bus.grant_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickAny) begin
            bus.grant_idx <= pickIdx;
            bus.regAddr   <= bus.req_addr[REG_AW*pickIdx +: REG_AW];
            bus.busy      <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          bus.rdata   <= bus.regData;
          bus.ack     <= N_REQ'(1) << bus.grant_idx;
          bus.regAddr <= '0;
          state       <= ACK;
        end
        ACK: begin
          bus.ack  <= '0;
          bus.busy <= 1'b0;
          ptr      <= (bus.grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                          : bus.grant_idx + IDX_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_dbg_port_arbiter.sv
module tb_sr_dbg_port_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem [32];
  int errors = 0;
  int checks = 0;

  sr_dbg_port_arbiter_if #(.N_REQ(N), .IDX_W(2)) bus ();
  assign bus.regData = mem[bus.regAddr];

  sr_dbg_port_arbiter #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [19:0] addr;
    int          expG;
    logic [4:0]  expAddr;
    logic [31:0] expData;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int refPick(input logic [3:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [6];
  logic [3:0]  reqS;
  logic [19:0] addrS;
  int gEdge, gIdx, lastG, mptr, k, nAck, lastAckCyc;
  logic [4:0]  gAddr;
  logic [31:0] lastRd;
  logic        eBusy;
  logic [4:0]  eAddr;
  logic [3:0]  eAck;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[7] = 32'h0000_00A5;
    mem[5] = 32'h5555_5555;
    mem[9] = 32'h9999_9999;
    bus.req = '0;
    bus.req_addr = '0;

    vecs[0] = '{4'b0100, {5'd4, 5'd7, 5'd2, 5'd1}, 2, 5'd7, 32'h0000_00A5};
    vecs[1] = '{4'b1001, {5'd4, 5'd3, 5'd2, 5'd1}, 3, 5'd4, 32'h1000_0004};
    vecs[2] = '{4'b1001, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 5'd1, 32'h1000_0001};
    vecs[3] = '{4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1, 5'd2, 32'h1000_0002};
    vecs[4] = '{4'b0001, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 5'd1, 32'h1000_0001};
    vecs[5] = '{4'b1000, {5'd4, 5'd3, 5'd2, 5'd1}, 3, 5'd4, 32'h1000_0004};

    // reset state, then idle
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {bus.busy, bus.regAddr, bus.ack, bus.grant_idx, bus.rdata}, 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle", {bus.busy, bus.regAddr, bus.ack, bus.rdata}, 64'd0);
    end

    // table-driven single transactions; ptr evolves across records
    for (int v = 0; v < 6; v++) begin
      bus.req = vecs[v].req;
      bus.req_addr = vecs[v].addr;
      tick();
      chk("tbl_read", {bus.busy, bus.regAddr, bus.ack, bus.grant_idx},
          {1'b1, vecs[v].expAddr, 4'b0, 2'(vecs[v].expG)});
      tick();
      chk("tbl_ack", {bus.ack, bus.grant_idx, bus.rdata},
          {4'(1 << vecs[v].expG), 2'(vecs[v].expG), vecs[v].expData});
      bus.req = '0;
      tick();
      chk("tbl_idle", {bus.busy, bus.regAddr, bus.ack}, 64'd0);
    end

    // address latched on grant edge
    bus.req = 4'b0010;
    bus.req_addr = {5'd4, 5'd3, 5'd5, 5'd1};
    tick();
    chk("latch_read", bus.regAddr, 5'd5);
    bus.req_addr[9:5] = 5'd9;
    tick();
    chk("latch_ack", {bus.ack, bus.rdata}, {4'b0010, 32'h5555_5555});
    bus.req = '0;
    tick();

    // reset during READ aborts; ptr restarts at 0 (ptr is 2 here)
    bus.req = 4'b1010;
    bus.req_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    tick();
    chk("pre_rst_read", {bus.grant_idx, bus.regAddr}, {2'd3, 5'd4});
    rst = 1'b1;
    #1;
    chk("rst_async", {bus.busy, bus.regAddr, bus.ack}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_noack", {bus.busy, bus.ack}, 64'd0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_read", {bus.grant_idx, bus.regAddr, bus.busy}, {2'd1, 5'd2, 1'b1});
    tick();
    chk("post_rst_ack", {bus.ack, bus.rdata}, {4'b0010, 32'h1000_0002});
    bus.req = '0;
    tick();

    // all requesting: order 0,1,2,3,0 with 3-cycle spacing
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    nAck = 0;
    lastAckCyc = -1;
    for (int c = 0; c < 30 && nAck < 5; c++) begin
      tick();
      if (bus.ack != 0) begin
        chk("rr_onehot", {bus.ack, bus.rdata},
            {4'(1 << order[nAck]), 32'h1000_0001 + 32'(order[nAck])});
        if (lastAckCyc >= 0) chk("rr_spacing", 64'(c - lastAckCyc), 64'd3);
        lastAckCyc = c;
        nAck++;
        bus.req = 4'b1111 & ~bus.ack;
      end else begin
        bus.req = 4'b1111;
      end
    end
    chk("rr_count", 64'(nAck), 64'd5);
    bus.req = '0;
    tick();
    tick();

    // randomized run against a transaction-timeline reference
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gEdge = -100; gIdx = 0; lastG = 0; mptr = 0; k = 0; lastRd = '0; gAddr = '0;
    for (int c = 0; c < 3000; c++) begin
      reqS = bus.req;
      addrS = bus.req_addr;
      @(posedge clk);
      k++;
      // a grant may happen on an edge at least 3 edges after the previous one
      if (k >= gEdge + 3 && reqS != 0) begin
        gIdx = refPick(reqS, mptr);
        gAddr = addrS[5*gIdx +: 5];
        gEdge = k;
        mptr = (gIdx + 1) % N;
        lastG = gIdx;
      end
      #1;
      eBusy = 1'b0; eAddr = '0; eAck = '0;
      if (gEdge == k) begin
        eBusy = 1'b1; eAddr = gAddr;
      end else if (gEdge == k - 1) begin
        eBusy = 1'b1; eAck = 4'(1 << gIdx); lastRd = mem[gAddr];
      end
      chk("rand", {bus.busy, bus.regAddr, bus.ack, bus.grant_idx, bus.rdata},
          {eBusy, eAddr, eAck, 2'(lastG), lastRd});
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i] = 1'b1;
            bus.req_addr[5*i +: 5] = 5'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
        else if ($urandom_range(0, 7) == 0) bus.req_addr[5*i +: 5] = 5'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
